// File: rtl/img2col_weight_pack_pkg.sv
// -----------------------------------------------------------------------------
// img2col_pkg
// Shared definitions for the img2col weight packer: element width, the
// controller state encoding and helpers that size the element counters.
// -----------------------------------------------------------------------------
package img2col_pkg;

  // Width of one weight element in bits.
  localparam int ELEM_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  // Packer fill count: holds values up to 2*ELEMS-1 right after an append.
  function automatic int cnt_width(input int elems);
    return $clog2(elems) + 1;
  endfunction

  // valid_num must be able to express ELEMS itself (a full word).
  function automatic int vn_width(input int elems);
    return $clog2(elems) + 1;
  endfunction

endpackage

// File: rtl/img2col_weight_pack_if.sv
// -----------------------------------------------------------------------------
// img2col_weight_pack_if
// Weight-buffer bus between the packer and the SRAM banks.
//   wgt_rd_addr / wgt_rd_en : shared read address, per-lane read strobes
//   wgt_in                  : read data, lane i at [i*DATA_W +: DATA_W]
//   wgt_wr_addr / wgt_wr_en : shared write address, per-lane write strobes
//   wgt_out                 : packed write data, lane i at [i*DATA_W +: DATA_W]
// master: the packer.  slave: the buffer.
// -----------------------------------------------------------------------------
interface img2col_weight_pack_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6
);

  logic [ADDR_W-1:0]       wgt_rd_addr;
  logic [LANES-1:0]        wgt_rd_en;
  logic [LANES*DATA_W-1:0] wgt_in;
  logic [ADDR_W-1:0]       wgt_wr_addr;
  logic [LANES-1:0]        wgt_wr_en;
  logic [LANES*DATA_W-1:0] wgt_out;

  modport master (
    output wgt_rd_addr, wgt_rd_en, wgt_wr_addr, wgt_wr_en, wgt_out,
    input  wgt_in
  );

  modport slave (
    input  wgt_rd_addr, wgt_rd_en, wgt_wr_addr, wgt_wr_en, wgt_out,
    output wgt_in
  );

endinterface

// File: rtl/img2col_weight_pack_lane.sv
// -----------------------------------------------------------------------------
// img2col_pack_lane
// One lane of the packing datapath. Appends the low v elements of each
// returned word at position cnt of a two-word accumulator; whenever a full
// word is available it is registered out (wr_fire) and the accumulator
// shifts down by one word. flush emits the remaining partial word,
// zero-filled above cnt.
//   clock, rst_n : clock, synchronous active-low reset
//   en           : lane enable; a disabled lane presents zero data
//   data_vld     : din carries a returned source word this cycle
//   flush        : emit the partial word if one is pending
//   v            : valid elements per source word (1..ELEMS)
//   din          : source word
//   wr_fire      : a write is presented this cycle (unmasked)
//   dout         : write data
// -----------------------------------------------------------------------------
module img2col_pack_lane
  import img2col_pkg::*;
#(
  parameter int DATA_W = 128,
  localparam int ELEMS = DATA_W / ELEM_W,
  localparam int CNT_W = cnt_width(ELEMS),
  localparam int VN_W  = vn_width(ELEMS)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              en,
  input  logic              data_vld,
  input  logic              flush,
  input  logic [VN_W-1:0]   v,
  input  logic [DATA_W-1:0] din,
  output logic              wr_fire,
  output logic [DATA_W-1:0] dout
);

  localparam int ACC_W = 2 * DATA_W;

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  appended;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  sum;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] data_q;

  // Elements at and above cnt_q are always zero, so an OR is enough to
  // place the new elements behind the ones already held.
  always_comb begin
    keep     = ~({DATA_W{1'b1}} << (v * ELEM_W));
    appended = acc_q | ({{DATA_W{1'b0}}, din & keep} << (cnt_q * ELEM_W));
    sum      = cnt_q + CNT_W'(v);
  end

  // NOTE: every register here updates with <= so all lanes and the
  // controller see pre-edge values at the same clock edge.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      // NOTE: the accumulator is plain flops, not a RAM, so it is reset;
      // a job aborted by reset must not leak its partial word into the next.
      acc_q   <= '0;
      cnt_q   <= '0;
      wr_fire <= 1'b0;
      data_q  <= '0;
    end else begin
      wr_fire <= 1'b0;
      if (data_vld) begin
        if (sum >= CNT_W'(ELEMS)) begin
          acc_q   <= appended >> DATA_W;
          cnt_q   <= sum - CNT_W'(ELEMS);
          wr_fire <= 1'b1;
          data_q  <= appended[DATA_W-1:0];
        end else begin
          acc_q <= appended;
          cnt_q <= sum;
        end
      end else if (flush && (cnt_q != '0)) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        wr_fire <= 1'b1;
        data_q  <= acc_q[DATA_W-1:0];
      end
    end
  end

  assign dout = en ? data_q : '0;

endmodule

// File: rtl/img2col_weight_pack.sv
// -----------------------------------------------------------------------------
// img2col_weight_pack
// Shared controller for LANES packing lanes. On an accepted start it reads
// K*K consecutive source words per lane, waits RD_LAT cycles for the last
// data, flushes any partial word and pulses i2c_done. Packed words are
// written to consecutive addresses from wr_base. Addresses wrap mod 2^ADDR_W.
//   clock, rst_n      : clock, synchronous active-low reset
//   i2c_wgt_start     : start request, taken only while i2c_ready
//   kernel_size       : K (1..7)
//   valid_num         : valid elements per source word (1..ELEMS)
//   lane_mask         : per-lane enable, latched at start
//   rd_base / wr_base : first source / destination address
//   i2c_ready         : idle, can accept a start
//   i2c_done          : one-cycle pulse at job end
//   i2c_err           : last start had an illegal configuration
//   bus               : weight-buffer read/write bus (master side)
// -----------------------------------------------------------------------------
module img2col_weight_pack
  import img2col_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1,
  localparam int ELEMS = DATA_W / ELEM_W,
  localparam int VN_W  = vn_width(ELEMS)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 i2c_wgt_start,
  input  logic [2:0]           kernel_size,
  input  logic [VN_W-1:0]      valid_num,
  input  logic [LANES-1:0]     lane_mask,
  input  logic [ADDR_W-1:0]    rd_base,
  input  logic [ADDR_W-1:0]    wr_base,
  output logic                 i2c_ready,
  output logic                 i2c_done,
  output logic                 i2c_err,
  img2col_weight_pack_if.master bus
);

  state_t                  state_q, state_d;
  logic [5:0]              kk_q;
  logic [5:0]              n_q;
  logic [VN_W-1:0]         v_q;
  logic [LANES-1:0]        mask_q;
  logic [ADDR_W-1:0]       rd_ptr_q;
  logic [ADDR_W-1:0]       wr_ptr_q;
  logic [1:0]              drain_q;
  logic [RD_LAT-1:0]       vld_sr;
  logic                    err_q;
  logic                    start_ok;
  logic                    cfg_legal;
  logic                    last_read;
  logic                    drain_last;
  logic                    flush;
  logic [LANES-1:0]        wr_fire;
  logic [LANES*DATA_W-1:0] wgt_out_w;

  assign start_ok   = i2c_wgt_start && (state_q == IDLE);
  assign cfg_legal  = (kernel_size != 3'd0) && (valid_num != '0) &&
                      (valid_num <= VN_W'(ELEMS));
  assign last_read  = (n_q == kk_q - 6'd1);
  assign drain_last = (drain_q == 2'(RD_LAT - 1));
  assign flush      = (state_q == FLUSH);

  // NOTE: state_d gets its default before the case so no path through the
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = cfg_legal ? READ : DONE;
      READ:    if (last_read) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kk_q     <= '0;
      n_q      <= '0;
      v_q      <= '0;
      mask_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      drain_q  <= '0;
      vld_sr   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Tap RD_LAT-1 marks the cycle in which a read issued RD_LAT cycles
      // earlier has its data on wgt_in.
      vld_sr  <= (vld_sr << 1) | RD_LAT'(state_q == READ);
      drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;

      if (start_ok) begin
        kk_q     <= 6'(kernel_size) * 6'(kernel_size);
        v_q      <= valid_num;
        mask_q   <= lane_mask;
        rd_ptr_q <= rd_base;
        wr_ptr_q <= wr_base;
        n_q      <= '0;
        err_q    <= !cfg_legal;
      end

      if (state_q == READ) begin
        n_q      <= n_q + 6'd1;
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end

      // Lanes run in lock-step, so lane 0 paces the shared write address.
      if (wr_fire[0]) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    img2col_pack_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clock    (clock),
      .rst_n    (rst_n),
      .en       (mask_q[i]),
      .data_vld (vld_sr[RD_LAT-1]),
      .flush    (flush),
      .v        (v_q),
      .din      (bus.wgt_in[i*DATA_W +: DATA_W]),
      .wr_fire  (wr_fire[i]),
      .dout     (wgt_out_w[i*DATA_W +: DATA_W])
    );
  end

  assign i2c_ready       = (state_q == IDLE);
  assign i2c_done        = (state_q == DONE);
  assign i2c_err         = err_q;
  assign bus.wgt_rd_addr = rd_ptr_q;
  assign bus.wgt_rd_en   = (state_q == READ) ? mask_q : '0;
  assign bus.wgt_wr_addr = wr_ptr_q;
  assign bus.wgt_wr_en   = wr_fire & mask_q;
  assign bus.wgt_out     = wgt_out_w;

endmodule
